// File: rtl/riscv_commit_checker.sv
// Writeback snooper and register-file result checker; captures a shadow RF for RUN_CYCLES
// cycles, then walks an expected-value table. Optional retire counter: COMMIT_CHECK_RETIRE_CNT_EN.

module riscv_commit_checker_shadow_reg #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  input  logic            we,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);
  always_ff @(posedge clock or posedge reset)
    if (reset)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
endmodule

module riscv_commit_checker #(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 16,
  parameter int RUN_CYCLES = 22,
  parameter int CNT_W      = 16,
  parameter int IDX_W      = $clog2(NUM_CHECKS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_idx,
  input  logic [4:0]       exp_rd,
  input  logic [XLEN-1:0]  exp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [XLEN-1:0]  first_fail_got,
  output logic [31:0]      retired
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  typedef struct packed {
    logic            vld;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  state_t                      state, state_nxt;
  exp_t [NUM_CHECKS-1:0]       tbl;
  logic [31:0][XLEN-1:0]       shadow;
  logic [CNT_W-1:0]            cyc_cnt;
  logic [IDX_W-1:0]            chk_idx;
  logic                        idle_or_done, launch, run_last, chk_last, capture, mismatch;
  exp_t                        cur;
  logic [XLEN-1:0]             cur_got;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign launch       = idle_or_done && start;
  assign run_last     = (state == RUN) && (cyc_cnt == CNT_W'(RUN_CYCLES-1));
  assign chk_last     = (state == CHECK) && (chk_idx == IDX_W'(NUM_CHECKS-1));
  assign capture      = (state == RUN) && wb_reg_write && (wb_rd != 5'd0);
  assign cur          = tbl[chk_idx];
  assign cur_got      = shadow[cur.rd];
  assign mismatch     = (state == CHECK) && cur.vld && (cur_got != cur.data);

  assign busy = (state == RUN) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (fail_count == '0);

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)    state_nxt = RUN;
      RUN:        if (run_last) state_nxt = CHECK;
      CHECK:      if (chk_last) state_nxt = DONE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // x0 is hardwired; one capture register per architectural register 1..31
  assign shadow[0] = '0;
  for (genvar r = 1; r < 32; r++) begin : g_shadow
    riscv_commit_checker_shadow_reg #(.XLEN(XLEN)) u_reg (
      .clock (clock),
      .reset (reset),
      .clr   (launch),
      .we    (capture && (wb_rd == 5'(r))),
      .d     (wb_data),
      .q     (shadow[r])
    );
  end

  // table is frozen while busy so a run checks against a stable snapshot
  always_ff @(posedge clock or posedge reset)
    if (reset)
      tbl <= '0;
    else if (exp_we && idle_or_done)
      tbl[exp_idx] <= '{vld: 1'b1, rd: exp_rd, data: exp_data};

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cyc_cnt        <= '0;
      chk_idx        <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
    end else if (launch) begin
      cyc_cnt        <= '0;
      chk_idx        <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
    end else begin
      if ((state == RUN) && !run_last)   cyc_cnt <= cyc_cnt + 1'b1;
      if ((state == CHECK) && !chk_last) chk_idx <= chk_idx + 1'b1;
      if (mismatch) begin
        fail_count <= fail_count + 1'b1;
        if (fail_count == '0) begin
          first_fail_idx <= chk_idx;
          first_fail_got <= cur_got;
        end
      end
    end

`ifdef COMMIT_CHECK_RETIRE_CNT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset)                           retired <= '0;
    else if (launch)                     retired <= '0;
    else if (capture && (retired != '1)) retired <= retired + 1'b1;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Directed bench for riscv_commit_checker: reference model of run window and table check,
// per-cycle compare against it, plus literal expectations per scenario.

module tb_riscv_commit_checker;
  localparam int RUN = 22;
  localparam int NUM = 16;

  logic        clock = 0, reset = 1, start = 0;
  logic        wb_reg_write = 0;
  logic [4:0]  wb_rd = 0;
  logic [31:0] wb_data = 0;
  logic        exp_we = 0;
  logic [3:0]  exp_idx = 0;
  logic [4:0]  exp_rd = 0;
  logic [31:0] exp_data = 0;
  logic        busy, done, pass;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;
  logic [31:0] first_fail_got, retired;

  int checks = 0, errors = 0, cyc = 0, t0 = 0;

  riscv_commit_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_rd(exp_rd), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .first_fail_got(first_fail_got), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // reference model: elapsed cycles since start, table, shadow values
  bit          m_active = 0;
  int          m_el = 0, m_ret = 0;
  bit          m_vld [NUM];
  logic [4:0]  m_rd  [NUM];
  logic [31:0] m_dt  [NUM];
  logic [31:0] m_sh  [32];
  int          e_fail = 0, e_idx = 0, e_ret = 0;
  logic [31:0] e_got = 0;

  function automatic bit m_busy();
    return m_active && (m_el < RUN + NUM);
  endfunction

  function automatic bit m_done();
    return m_active && (m_el >= RUN + NUM);
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_active = 0;
      m_el = 0;
      foreach (m_vld[i]) m_vld[i] = 0;
    end else if (!m_busy()) begin
      if (exp_we) begin
        m_vld[exp_idx] = 1;
        m_rd[exp_idx]  = exp_rd;
        m_dt[exp_idx]  = exp_data;
      end
      if (start) begin
        m_active = 1;
        m_el = 0;
        m_ret = 0;
        foreach (m_sh[i]) m_sh[i] = 0;
      end
    end else begin
      if (m_el < RUN && wb_reg_write && wb_rd != 0) begin
        m_sh[wb_rd] = wb_data;
        m_ret++;
      end
      m_el++;
      if (m_el == RUN + NUM) begin
        e_fail = 0; e_idx = 0; e_got = 0;
        for (int i = 0; i < NUM; i++)
          if (m_vld[i] && m_sh[m_rd[i]] != m_dt[i]) begin
            if (e_fail == 0) begin e_idx = i; e_got = m_sh[m_rd[i]]; end
            e_fail++;
          end
        e_ret = m_ret;
      end
    end
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("busy", busy, m_busy());
      chk("done", done, m_done());
      if (m_done()) begin
        chk("pass", pass, e_fail == 0);
        chk("fail_count", fail_count, e_fail);
        chk("first_fail_idx", first_fail_idx, e_idx);
        chk("first_fail_got", first_fail_got, e_got);
`ifdef COMMIT_CHECK_RETIRE_CNT_EN
        chk("retired", retired, e_ret);
`else
        chk("retired", retired, 0);
`endif
      end
    end
  end

  task automatic load(input int idx, input int rd, input logic [31:0] d);
    exp_we = 1; exp_idx = 4'(idx); exp_rd = 5'(rd); exp_data = d;
    @(negedge clock);
    exp_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clock);
    start = 0;
    t0 = cyc;
  endtask

  task automatic drive_wb(input int rd, input logic [31:0] d);
    wb_reg_write = 1; wb_rd = 5'(rd); wb_data = d;
    @(negedge clock);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    wb_reg_write = 0;
    while (!done && n < 200) begin @(negedge clock); n++; end
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_latency"}, cyc - t0, RUN + NUM);
  endtask

  task automatic chk_ret(input string nm, input int n);
`ifdef COMMIT_CHECK_RETIRE_CNT_EN
    chk(nm, retired, n);
`else
    chk(nm, retired, 0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_first_idx", first_fail_idx, 0);
    chk("rst_first_got", first_fail_got, 0);
    chk("rst_retired", retired, 0);
    reset = 0;
    @(negedge clock);

    // 1: all matching
    load(0, 3, 32'h11); load(1, 4, 32'h14); load(2, 5, 32'h20);
    do_start();
    drive_wb(3, 32'h11); drive_wb(4, 32'h14); drive_wb(5, 32'h20);
    wait_done("t1");
    chk("t1_pass", pass, 1);
    chk("t1_fail_count", fail_count, 0);
    chk_ret("t1_retired", 3);

    // 2: one mismatch on entry 2
    do_start();
    drive_wb(3, 32'h11); drive_wb(4, 32'h14); drive_wb(5, 32'h21);
    wait_done("t2");
    chk("t2_pass", pass, 0);
    chk("t2_fail_count", fail_count, 1);
    chk("t2_first_idx", first_fail_idx, 2);
    chk("t2_first_got", first_fail_got, 32'h21);

    // 3: back-to-back writes, last wins
    load(3, 9, 32'h12345678);
    do_start();
    drive_wb(3, 32'h11); drive_wb(4, 32'h14); drive_wb(5, 32'h20);
    drive_wb(9, 32'h00FF01FF); drive_wb(9, 32'h12345678);
    wait_done("t3");
    chk("t3_pass", pass, 1);
    chk_ret("t3_retired", 5);

    // 4: x0 writes discarded and not counted
    load(4, 0, 32'h0);
    do_start();
    drive_wb(3, 32'h11); drive_wb(4, 32'h14); drive_wb(5, 32'h20);
    drive_wb(9, 32'h12345678); drive_wb(0, 32'hDEAD);
    wait_done("t4");
    chk("t4_pass", pass, 1);
    chk_ret("t4_retired", 4);

    // 5a: start and exp_we during RUN are ignored
    do_start();
    drive_wb(3, 32'h11); drive_wb(4, 32'h14); drive_wb(5, 32'h20);
    drive_wb(9, 32'h12345678);
    wb_reg_write = 0;
    start = 1; exp_we = 1; exp_idx = 0; exp_rd = 3; exp_data = 32'h99;
    @(negedge clock);
    start = 0; exp_we = 0;
    wait_done("t5a");
    chk("t5a_pass", pass, 1);

    // 5b: reset during CHECK clears everything
    do_start();
    repeat (25) @(negedge clock);
    chk("t5b_busy_in_check", busy, 1);
    reset = 1;
    #1;
    chk("t5b_rst_busy", busy, 0);
    chk("t5b_rst_done", done, 0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    do_start();
    wait_done("t5c");
    chk("t5c_pass", pass, 1);
    chk("t5c_fail_count", fail_count, 0);

    // 6: last RUN cycle captured, first CHECK cycle ignored
    load(0, 6, 32'h66); load(1, 7, 32'h77);
    do_start();
    repeat (RUN - 1) @(negedge clock);
    drive_wb(6, 32'h66); drive_wb(7, 32'h77);
    wait_done("t6");
    chk("t6_pass", pass, 0);
    chk("t6_fail_count", fail_count, 1);
    chk("t6_first_idx", first_fail_idx, 1);
    chk("t6_first_got", first_fail_got, 0);
    chk_ret("t6_retired", 1);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
